// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider
//   Multi-cycle unsigned restoring divider, one quotient bit per clock.
//   Each step subtracts the divisor by adding its one's complement with a
//   carry-in of 1, the same add/subtract scheme as the ripple adder/subtractor.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request, sampled on rising edge in IDLE or DONE
//   dividend     unsigned dividend, latched on accepted start
//   divisor      unsigned divisor, latched on accepted start
//   busy         high while iterating (RUN)
//   done         one-cycle pulse, results valid
//   quotient     registered quotient (all ones on divide by zero)
//   remainder    registered remainder (dividend on divide by zero)
//   div_by_zero  registered flag for the last completed operation
module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [WIDTH:0]   r_rem;      // partial remainder, one guard bit
    logic [WIDTH-1:0] r_q;        // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] r_div;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remo;
    logic             r_dbz;

    logic [WIDTH:0]   w_r_sh;
    logic [WIDTH-1:0] w_q_sh;
    logic [WIDTH:0]   w_t;
    logic [WIDTH:0]   w_r_next;
    logic [WIDTH-1:0] w_q_next;

    // Shift {R,Q} left by one, then trial-subtract D via one's complement + 1.
    // The partial remainder is always below D, so the shifted value is below
    // 2*D and bit WIDTH of the trial result is a clean borrow indicator.
    always_comb begin
        w_r_sh   = {r_rem[WIDTH-1:0], r_q[WIDTH-1]};
        w_q_sh   = {r_q[WIDTH-2:0], 1'b0};
        w_t      = w_r_sh + ~{1'b0, r_div} + {{WIDTH{1'b0}}, 1'b1};
        w_r_next = w_t[WIDTH] ? w_r_sh : w_t;
        w_q_next = {w_q_sh[WIDTH-1:1], ~w_t[WIDTH]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_q     <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_remo  <= '0;
            r_dbz   <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_rem <= w_r_next;
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_quot  <= w_q_next;
                        r_remo  <= w_r_next[WIDTH-1:0];
                        r_dbz   <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                default: begin
                    // IDLE and DONE accept a new request identically, which
                    // gives back-to-back operation out of DONE.
                    r_done <= 1'b0;
                    r_busy <= 1'b0;
                    if (start) begin
                        if (divisor == '0) begin
                            r_quot  <= '1;
                            r_remo  <= dividend;
                            r_dbz   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_div   <= divisor;
                            r_q     <= dividend;
                            r_rem   <= '0;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quot;
    assign remainder   = r_remo;
    assign div_by_zero = r_dbz;

endmodule
